// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, direction and result encodings, controller state
// type and the error-priority helper used by the maze job controller.
package maze_pkg;

  localparam int N             = 17;
  localparam int NN            = N * N;
  localparam int SOLVE_TIMEOUT = 63;
  localparam int MAX_STEPS     = 289;
  localparam int COOLDOWN      = 2;

  // Sized copies so register compares stay width-matched.
  localparam logic [4:0] N_POS    = 5'(N);
  localparam logic [4:0] COL_LAST = 5'(N - 1);
  localparam logic [8:0] BIT_LAST = 9'(NN - 1);
  localparam logic [8:0] STEP_MAX = 9'(MAX_STEPS);
  localparam logic [5:0] WD_LAST  = 6'(SOLVE_TIMEOUT - 1);
  localparam logic [1:0] CD_INIT  = 2'(COOLDOWN - 1);

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_UP    = 2'd3;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_BAD_PATH = 2'd2;
  localparam logic [1:0] ERR_TOO_LONG = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_SOLVE,
    S_STREAM,
    S_REPORT,
    S_COOLDOWN
  } state_t;

  // Timeout outranks too-long, which outranks bad path.
  function automatic logic [1:0] pick_err(input logic timeout,
                                          input logic too_long,
                                          input logic bad_path);
    if (timeout)       return ERR_TIMEOUT;
    else if (too_long) return ERR_TOO_LONG;
    else if (bad_path) return ERR_BAD_PATH;
    else               return ERR_OK;
  endfunction

endpackage

// File: rtl/maze_row_serializer.sv
// maze_row_serializer: two-entry ping-pong row buffer feeding the solver's
// 1-bit load stream, row-major, bit k of each word first.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   en                      controller allows row acceptance
//   row_valid/row_data      host row word
//   row_ready               a row can be taken this cycle
//   sol_in_valid/sol_in     serial load stream to the solver
//   load_done               high in the cycle carrying the last of N*N bits
module maze_row_serializer import maze_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         row_valid,
  input  logic [N-1:0] row_data,
  output logic         row_ready,
  output logic         sol_in_valid,
  output logic         sol_in,
  output logic         load_done
);

  logic [N-1:0] buf_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   fill;
  logic [4:0]   rows_acc;
  logic [4:0]   col;
  logic [8:0]   bit_cnt;
  logic         push;
  logic         pop;

  assign row_ready    = en && (fill != 2'd2) && (rows_acc < N_POS);
  assign sol_in_valid = (fill != 2'd0);
  assign sol_in       = sol_in_valid && buf_q[rd_ptr][col];
  assign load_done    = sol_in_valid && (bit_cnt == BIT_LAST);
  assign push         = row_valid && row_ready;
  assign pop          = sol_in_valid && (col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '{default: '0};
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fill     <= 2'd0;
      rows_acc <= 5'd0;
      col      <= 5'd0;
      bit_cnt  <= 9'd0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= row_data;
        wr_ptr        <= ~wr_ptr;
        rows_acc      <= rows_acc + 5'd1;
      end
      // An empty buffer simply stalls the stream; counters hold.
      if (sol_in_valid) begin
        col     <= pop ? 5'd0 : col + 5'd1;
        bit_cnt <= load_done ? 9'd0 : bit_cnt + 9'd1;
        if (pop) rd_ptr <= ~rd_ptr;
      end
      fill <= fill + {1'b0, push} - {1'b0, pop};
      if (load_done) begin
        rows_acc <= 5'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/maze_job_ctrl.sv
// maze_job_ctrl: loads a 17x17 maze into the solver core, supervises the
// solve with a watchdog, forwards and checks the move stream and issues one
// result record per job, then enforces the solver's recovery gap.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   row_valid/row_data/row_ready      host row handshake
//   sol_in_valid/sol_in               solver load stream
//   sol_out_valid/sol_out             solver move stream
//   mv_valid/mv_dir                   forwarded moves (1-cycle latency)
//   res_valid/res_steps/res_err       per-job result pulse
//   busy                              job in progress
//
// state        | meaning
// S_IDLE       | waiting for the first row of a job
// S_LOAD       | accepting rows and serializing them to the solver
// S_WAIT_SOLVE | load complete, watchdog running until first move
// S_STREAM     | forwarding moves, tracking position and step count
// S_REPORT     | one-cycle result pulse
// S_COOLDOWN   | solver recovery gap, no rows accepted
module maze_job_ctrl import maze_pkg::*; (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         row_valid,
  input  logic [N-1:0] row_data,
  output logic         row_ready,
  output logic         sol_in_valid,
  output logic         sol_in,
  input  logic         sol_out_valid,
  input  logic [1:0]   sol_out,
  output logic         mv_valid,
  output logic [1:0]   mv_dir,
  output logic         res_valid,
  output logic [8:0]   res_steps,
  output logic [1:0]   res_err,
  output logic         busy
);

  state_t     state;
  logic       accept_en;
  logic       load_done;
  logic [5:0] wd;
  logic [1:0] cd;
  logic [8:0] steps;
  logic [4:0] pos_r;
  logic [4:0] pos_c;
  logic       bad_path;
  logic       too_long;
  logic [4:0] r_nxt;
  logic [4:0] c_nxt;
  logic       off_grid;
  logic       take_move;
  logic       at_goal;

  maze_row_serializer u_ser (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (accept_en),
    .row_valid    (row_valid),
    .row_data     (row_data),
    .row_ready    (row_ready),
    .sol_in_valid (sol_in_valid),
    .sol_in       (sol_in),
    .load_done    (load_done)
  );

  assign busy      = (state != S_IDLE);
  assign take_move = sol_out_valid && ((state == S_WAIT_SOLVE) || (state == S_STREAM));
  assign at_goal   = (pos_r == N_POS) && (pos_c == N_POS);

  // Position after the incoming move; wrap-around of the 5-bit registers
  // lands outside 1..N and is caught as off-grid as well.
  always_comb begin
    r_nxt = pos_r;
    c_nxt = pos_c;
    case (sol_out)
      DIR_RIGHT: c_nxt = pos_c + 5'd1;
      DIR_DOWN:  r_nxt = pos_r + 5'd1;
      DIR_LEFT:  c_nxt = pos_c - 5'd1;
      default:   r_nxt = pos_r - 5'd1;
    endcase
    off_grid = (r_nxt == 5'd0) || (r_nxt > N_POS) || (c_nxt == 5'd0) || (c_nxt > N_POS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      accept_en <= 1'b0;
      wd        <= 6'd0;
      cd        <= 2'd0;
      steps     <= 9'd0;
      pos_r     <= 5'd1;
      pos_c     <= 5'd1;
      bad_path  <= 1'b0;
      too_long  <= 1'b0;
      mv_valid  <= 1'b0;
      mv_dir    <= 2'd0;
      res_valid <= 1'b0;
      res_steps <= 9'd0;
      res_err   <= 2'd0;
    end else begin
      mv_valid  <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          accept_en <= 1'b1;
          if (row_valid && row_ready) state <= S_LOAD;
        end
        S_LOAD: begin
          if (load_done) begin
            state     <= S_WAIT_SOLVE;
            accept_en <= 1'b0;
            // The last load-bit cycle counts as watchdog cycle 0.
            wd        <= 6'd1;
            steps     <= 9'd0;
            pos_r     <= 5'd1;
            pos_c     <= 5'd1;
            bad_path  <= 1'b0;
            too_long  <= 1'b0;
          end
        end
        S_WAIT_SOLVE: begin
          if (sol_out_valid) begin
            state <= S_STREAM;
          end else begin
            wd <= wd + 6'd1;
            if (wd == WD_LAST) begin
              state     <= S_REPORT;
              res_valid <= 1'b1;
              res_steps <= 9'd0;
              res_err   <= ERR_TIMEOUT;
            end
          end
        end
        S_STREAM: begin
          if (!sol_out_valid) begin
            state     <= S_REPORT;
            res_valid <= 1'b1;
            res_steps <= steps;
            res_err   <= pick_err(1'b0, too_long, bad_path || !at_goal);
          end
        end
        S_REPORT: begin
          state <= S_COOLDOWN;
          cd    <= CD_INIT;
        end
        S_COOLDOWN: begin
          if (cd == 2'd0) begin
            state     <= S_IDLE;
            accept_en <= 1'b1;
          end else begin
            cd <= cd - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (take_move) begin
        mv_valid <= 1'b1;
        mv_dir   <= sol_out;
        pos_r    <= r_nxt;
        pos_c    <= c_nxt;
        if (off_grid) bad_path <= 1'b1;
        if (steps == STEP_MAX) too_long <= 1'b1;
        else                   steps    <= steps + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_maze_job_ctrl.sv
module tb_maze_job_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        row_valid = 1'b0;
  logic [16:0] row_data = '0;
  logic        row_ready;
  logic        sol_in_valid;
  logic        sol_in;
  logic        sol_out_valid = 1'b0;
  logic [1:0]  sol_out = 2'd0;
  logic        mv_valid;
  logic [1:0]  mv_dir;
  logic        res_valid;
  logic [8:0]  res_steps;
  logic [1:0]  res_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit          got_bits[$];
  int          mv_q[$];
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [16:0] maze [17];
  int          moves[$];

  maze_job_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_valid     (row_valid),
    .row_data      (row_data),
    .row_ready     (row_ready),
    .sol_in_valid  (sol_in_valid),
    .sol_in        (sol_in),
    .sol_out_valid (sol_out_valid),
    .sol_out       (sol_out),
    .mv_valid      (mv_valid),
    .mv_dir        (mv_dir),
    .res_valid     (res_valid),
    .res_steps     (res_steps),
    .res_err       (res_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (sol_in_valid) begin
      if (got_bits.size() == 0) first_cyc = cyc;
      got_bits.push_back(sol_in);
      last_cyc = cyc;
    end
    if (mv_valid) mv_q.push_back(int'(mv_dir));
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout observed=expired expected=finish");
    $fatal(1, "global time limit");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, int'({row_ready, sol_in_valid, sol_in, mv_valid, mv_dir,
                   res_valid, res_steps, res_err, busy}), 0);
  endtask

  // Result model: walk the path from (1,1) on a plain integer grid.
  function automatic void ref_result(output int steps, output int err);
    int r = 1;
    int c = 1;
    bit bad = 0;
    foreach (moves[i]) begin
      case (moves[i])
        0: c++;
        1: r++;
        2: c--;
        default: r--;
      endcase
      if (r < 1 || r > 17 || c < 1 || c > 17) bad = 1;
    end
    if (r != 17 || c != 17) bad = 1;
    if (moves.size() == 0) begin
      steps = 0;
      err = 1;
    end else begin
      steps = (moves.size() > 289) ? 289 : moves.size();
      err = (moves.size() > 289) ? 3 : (bad ? 2 : 0);
    end
  endfunction

  task automatic drive_rows(input int nrows, input int gap, input bit rnd_gap, output int accepted);
    int n;
    int g;
    accepted = 0;
    for (int r = 0; r < nrows; r++) begin
      row_valid = 1'b1;
      row_data  = maze[r];
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!row_ready && n < 1000);
      if (!row_ready) begin
        row_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
      accepted++;
      row_valid = 1'b0;
      row_data  = '0;
      g = rnd_gap ? int'($urandom_range(0, 25)) : gap;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  // contig: 1 = load must be gap-free, 0 = gaps must appear, -1 = either
  task automatic run_job(input string tag, input int gap, input bit rnd_gap,
                         input int lat, input int contig);
    int n;
    int errs;
    int acc;
    int steps_exp;
    int err_exp;
    int res_cyc;
    bit seen;
    got_bits.delete();
    mv_q.delete();
    drive_rows(17, gap, rnd_gap, acc);
    chk({tag, "_rows"}, acc, 17);
    n = 0;
    while (got_bits.size() < 289 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bit_count"}, got_bits.size(), 289);
    errs = 0;
    for (int i = 0; i < got_bits.size() && i < 289; i++)
      if (got_bits[i] !== maze[i / 17][i % 17]) errs++;
    chk({tag, "_bit_order"}, errs, 0);
    if (contig == 1) chk({tag, "_contiguous"}, last_cyc - first_cyc, 288);
    else if (contig == 0) chk({tag, "_gaps"}, int'((last_cyc - first_cyc) > 288), 1);

    @(posedge clk); #1;
    repeat (lat) begin @(posedge clk); #1; end
    foreach (moves[i]) begin
      sol_out_valid = 1'b1;
      sol_out = 2'(moves[i]);
      @(posedge clk); #1;
    end
    sol_out_valid = 1'b0;
    sol_out = 2'd0;

    n = 0;
    seen = 0;
    res_cyc = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (res_valid) begin
        seen = 1;
        res_cyc = cyc;
        break;
      end
    end
    chk({tag, "_res_seen"}, int'(seen), 1);
    ref_result(steps_exp, err_exp);
    chk({tag, "_res_steps"}, int'(res_steps), steps_exp);
    chk({tag, "_res_err"}, int'(res_err), err_exp);
    chk({tag, "_busy_report"}, int'(busy), 1);
    if (moves.size() == 0) chk({tag, "_timeout_latency"}, res_cyc - last_cyc, 63);
    chk({tag, "_mv_count"}, mv_q.size(), moves.size());
    errs = 0;
    for (int i = 0; i < mv_q.size() && i < moves.size(); i++)
      if (mv_q[i] != moves[i]) errs++;
    chk({tag, "_mv_order"}, errs, 0);

    @(negedge clk);
    chk({tag, "_res_pulse"}, int'(res_valid), 0);
    chk({tag, "_cool_ready1"}, int'(row_ready), 0);
    @(negedge clk);
    chk({tag, "_cool_ready2"}, int'(row_ready), 0);
    @(negedge clk);
    chk({tag, "_idle_ready"}, int'(row_ready), 1);
    chk({tag, "_idle_busy"}, int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic set_corridor();
    maze[0] = 17'h1FFFF;
    for (int r = 1; r < 17; r++) maze[r] = 17'h10000;
    moves.delete();
    for (int i = 0; i < 16; i++) moves.push_back(0);
    for (int i = 0; i < 16; i++) moves.push_back(1);
  endtask

  task automatic set_random_maze();
    for (int r = 0; r < 17; r++) maze[r] = 17'($urandom);
  endtask

  initial begin
    int n;
    int acc;
    int j;
    int t;

    #12;
    chk_all_zero("reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ready_at_release", int'(row_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_reset", int'(row_ready), 1);
    chk("busy_after_reset", int'(busy), 0);

    set_corridor();
    run_job("corridor", 0, 1'b0, 3, 1);
    run_job("corridor_gap5", 5, 1'b0, 0, -1);
    run_job("corridor_gap20", 20, 1'b0, 7, 0);

    moves.delete();
    run_job("timeout", 0, 1'b0, 0, 1);

    moves.delete();
    moves.push_back(3);
    moves.push_back(0);
    run_job("off_grid", 0, 1'b0, 2, 1);

    moves.delete();
    for (int i = 0; i < 300; i++) moves.push_back(int'($urandom_range(0, 3)));
    run_job("too_long", 0, 1'b0, 1, 1);

    // Reset in the middle of a load.
    set_corridor();
    got_bits.delete();
    drive_rows(7, 0, 1'b0, acc);
    n = 0;
    while (got_bits.size() < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("midload_bits_reached", int'(got_bits.size() >= 100), 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midload_reset_outputs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midload_ready_at_release", int'(row_ready), 0);
    @(posedge clk); #1;
    run_job("after_reset", 0, 1'b0, 4, 1);

    // Randomized jobs: random maze contents, host gaps and solver latency;
    // paths are either a shuffled monotone path or a short random walk.
    for (int k = 0; k < 5; k++) begin
      set_random_maze();
      moves.delete();
      if ((k % 2) == 0) begin
        for (int i = 0; i < 16; i++) moves.push_back(0);
        for (int i = 0; i < 16; i++) moves.push_back(1);
        for (int i = 31; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          t = moves[i];
          moves[i] = moves[j];
          moves[j] = t;
        end
      end else begin
        n = int'($urandom_range(1, 40));
        for (int i = 0; i < n; i++) moves.push_back(int'($urandom_range(0, 3)));
      end
      run_job($sformatf("random%0d", k), 0, 1'b1, int'($urandom_range(0, 40)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
